// File: rtl/hollywood_pw_gen.sv
// Brute-force password candidate generator feeding the Hollywood unhash core.
// Enumerates every LEN-word password whose bytes lie in CHAR_LO..CHAR_HI, frames
// each candidate as mgmt word + LEN data words + gap, then samples the core's
// match flag. Stops on the first match (latched) or when the space is exhausted.
module hollywood_pw_gen #(
    parameter int unsigned LEN     = 2,
    parameter logic [7:0]  CHAR_LO = 8'h20,
    parameter logic [7:0]  CHAR_HI = 8'h7E
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    output logic                 out_valid,
    output logic                 out_channel,
    output logic [15:0]          out_data,
    input  logic                 match_valid,
    output logic                 busy,
    output logic                 done,
    output logic                 found,
    output logic [16*LEN-1:0]    found_data
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_MGMT,
        S_DATA,
        S_GAP,
        S_CHECK,
        S_DONE
    } state_t;

    localparam int unsigned NDIG = 2 * LEN;
    localparam int unsigned WW   = (LEN > 1) ? $clog2(LEN) : 1;
    localparam logic [16*LEN-1:0] FIRST_CAND = {NDIG{CHAR_LO}};

    state_t              state, state_n;
    logic [WW-1:0]       widx, widx_n;
    logic [16*LEN-1:0]   cand, cand_n, cand_inc;
    logic [16*LEN-1:0]   found_data_n;
    logic                found_n;
    logic                carry;
    logic                is_last;
    logic [15:0]         word_sel;
    logic                out_valid_n, out_channel_n, busy_n, done_n;
    logic [15:0]         out_data_n;

    // Odometer increment of the digit vector; carry out of the top digit marks the last candidate.
    always_comb begin
        cand_inc = cand;
        carry    = 1'b1;
        for (int unsigned d = 0; d < NDIG; d++) begin
            if (carry) begin
                if (cand[8*d +: 8] == CHAR_HI) begin
                    cand_inc[8*d +: 8] = CHAR_LO;
                end else begin
                    cand_inc[8*d +: 8] = cand[8*d +: 8] + 8'd1;
                    carry              = 1'b0;
                end
            end
        end
        is_last = carry;
    end

    // Next-state logic; outputs are derived from the next state so they can be registered.
    always_comb begin
        state_n      = state;
        widx_n       = widx;
        cand_n       = cand;
        found_n      = found;
        found_data_n = found_data;
        case (state)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_n      = S_MGMT;
                    cand_n       = FIRST_CAND;
                    found_n      = 1'b0;
                    found_data_n = '0;
                end
            end
            S_MGMT: begin
                state_n = S_DATA;
                widx_n  = '0;
            end
            S_DATA: begin
                if (widx == WW'(LEN - 1)) begin
                    state_n = S_GAP;
                end else begin
                    widx_n = widx + 1'b1;
                end
            end
            S_GAP: begin
                state_n = S_CHECK;
            end
            S_CHECK: begin
                if (match_valid) begin
                    found_n      = 1'b1;
                    found_data_n = cand;
                    state_n      = S_DONE;
                end else if (is_last) begin
                    found_n = 1'b0;
                    state_n = S_DONE;
                end else begin
                    cand_n  = cand_inc;
                    state_n = S_MGMT;
                end
            end
            default: begin
                state_n = S_IDLE;
            end
        endcase
    end

    // Registered-output decode from the next state, with data forced to zero outside DATA.
    always_comb begin
        word_sel = '0;
        for (int unsigned k = 0; k < LEN; k++) begin
            if (widx_n == WW'(k)) begin
                word_sel = cand_n[16*k +: 16];
            end
        end
        out_valid_n   = (state_n == S_MGMT) || (state_n == S_DATA);
        out_channel_n = (state_n == S_MGMT);
        out_data_n    = (state_n == S_DATA) ? word_sel : '0;
        busy_n        = (state_n == S_MGMT) || (state_n == S_DATA) ||
                        (state_n == S_GAP)  || (state_n == S_CHECK);
        done_n        = (state_n == S_DONE);
    end

    // State, candidate and output registers with asynchronous reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= S_IDLE;
            widx        <= '0;
            cand        <= '0;
            out_valid   <= 1'b0;
            out_channel <= 1'b0;
            out_data    <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            found       <= 1'b0;
            found_data  <= '0;
        end else begin
            state       <= state_n;
            widx        <= widx_n;
            cand        <= cand_n;
            out_valid   <= out_valid_n;
            out_channel <= out_channel_n;
            out_data    <= out_data_n;
            busy        <= busy_n;
            done        <= done_n;
            found       <= found_n;
            found_data  <= found_data_n;
        end
    end

endmodule

// File: tb/tb_hollywood_pw_gen.sv
// Self-checking bench for hollywood_pw_gen (LEN=2, bytes 41..42, plus a
// single-candidate LEN=1 instance).
module tb_hollywood_pw_gen;

    localparam int unsigned LO  = 8'h41;
    localparam int unsigned RAD = 2;

    logic        clk;
    logic        reset;
    logic        start;
    logic        out_valid, out_channel;
    logic [15:0] out_data;
    logic        match_valid;
    logic        busy, done, found;
    logic [31:0] found_data;

    logic        start2;
    logic        out_valid2, out_channel2;
    logic [15:0] out_data2;
    logic        match_valid2;
    logic        busy2, done2, found2;
    logic [15:0] found_data2;

    // stand-in for the unhash core: matches one fixed password
    logic        core_en;
    logic [31:0] core_target;
    logic [31:0] cap;
    logic        last_v;
    logic        core_match;
    logic        spur_en;

    int unsigned compared;
    int unsigned mismatched;

    logic [17:0] exp_q[$];
    logic [17:0] exp2_q[$];

    hollywood_pw_gen #(.LEN(2), .CHAR_LO(8'h41), .CHAR_HI(8'h42)) dut (
        .clk(clk), .reset(reset), .start(start),
        .out_valid(out_valid), .out_channel(out_channel), .out_data(out_data),
        .match_valid(match_valid),
        .busy(busy), .done(done), .found(found), .found_data(found_data)
    );

    hollywood_pw_gen #(.LEN(1), .CHAR_LO(8'h5A), .CHAR_HI(8'h5A)) dut1 (
        .clk(clk), .reset(reset), .start(start2),
        .out_valid(out_valid2), .out_channel(out_channel2), .out_data(out_data2),
        .match_valid(match_valid2),
        .busy(busy2), .done(done2), .found(found2), .found_data(found_data2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            cap        <= '0;
            last_v     <= 1'b0;
            core_match <= 1'b0;
        end else begin
            last_v <= out_valid;
            if (out_valid && !out_channel) cap <= {out_data, cap[31:16]};
            core_match <= core_en && last_v && !out_valid && (cap == core_target);
        end
    end

    assign match_valid = core_match | (spur_en & (out_valid | (last_v & ~out_valid)));

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push_cands(input int unsigned n);
        int unsigned v;
        logic [7:0]  lb, hb;
        for (int unsigned i = 0; i < n; i++) begin
            v = i;
            exp_q.push_back({1'b1, 1'b1, 16'h0000});
            for (int unsigned k = 0; k < 2; k++) begin
                lb = 8'(LO + v % RAD); v = v / RAD;
                hb = 8'(LO + v % RAD); v = v / RAD;
                exp_q.push_back({1'b1, 1'b0, hb, lb});
            end
            exp_q.push_back(18'h0);
            exp_q.push_back(18'h0);
        end
    endtask

    task automatic step_cmp(input string tag);
        logic [17:0] e;
        e = (exp_q.size() > 0) ? exp_q.pop_front() : 18'h3FFFF;
        check(tag, 64'({out_valid, out_channel, out_data}), 64'(e));
        check({tag, "_busy"}, 64'(busy), 64'(1));
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_valid"}, 64'(out_valid), 64'(0));
        check({tag, "_chan"},  64'(out_channel), 64'(0));
        check({tag, "_data"},  64'(out_data), 64'(0));
        check({tag, "_busy"},  64'(busy), 64'(0));
        check({tag, "_done"},  64'(done), 64'(0));
        check({tag, "_found"}, 64'(found), 64'(0));
        check({tag, "_fdata"}, 64'(found_data), 64'(0));
    endtask

    initial begin
        logic [17:0] e2;
        compared = 0; mismatched = 0;
        reset = 1'b1; start = 1'b0; start2 = 1'b0; match_valid2 = 1'b0;
        spur_en = 1'b0; core_en = 1'b0; core_target = '0;
        #3;
        check_idle_outputs("reset");
        @(negedge clk); @(negedge clk);
        reset = 1'b0;

        // exhaustion, with start pulses during busy
        core_en = 1'b1; core_target = 32'h1234_5678;
        @(negedge clk); start = 1'b1;
        push_cands(16);
        for (int k = 0; k < 80; k++) begin
            @(negedge clk);
            if (k == 0 || k == 21) start = 1'b0;
            if (k == 20) start = 1'b1;
            step_cmp("exh");
        end
        @(negedge clk);
        check("exh_done",  64'(done), 64'(1));
        check("exh_found", 64'(found), 64'(0));
        check("exh_busy",  64'(busy), 64'(0));
        check("exh_fdata", 64'(found_data), 64'(0));
        check("exh_valid", 64'(out_valid), 64'(0));

        // restart from DONE, match on candidate 6
        core_target = 32'h4142_4241;
        start = 1'b1;
        push_cands(7);
        for (int k = 0; k < 35; k++) begin
            @(negedge clk);
            if (k == 0) begin
                start = 1'b0;
                check("match_done_clr",  64'(done), 64'(0));
                check("match_found_clr", 64'(found), 64'(0));
            end
            step_cmp("match");
        end
        @(negedge clk);
        check("match_done",  64'(done), 64'(1));
        check("match_found", 64'(found), 64'(1));
        check("match_fdata", 64'(found_data), 64'(32'h4142_4241));
        check("match_busy",  64'(busy), 64'(0));

        // asynchronous reset while holding a result
        #2 reset = 1'b1;
        #1 check_idle_outputs("rst_done");
        @(negedge clk); reset = 1'b0;

        // asynchronous reset mid-DATA, then restart from the first candidate
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        @(negedge clk);
        check("mid_pre_valid", 64'({out_valid, out_channel, out_data}), 64'({2'b10, 16'h4141}));
        #2 reset = 1'b1;
        #1 check_idle_outputs("rst_mid");
        @(negedge clk); reset = 1'b0;
        exp_q.delete();
        @(negedge clk); start = 1'b1;
        push_cands(2);
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (k == 0) start = 1'b0;
            step_cmp("restart");
        end
        #2 reset = 1'b1;
        @(negedge clk); reset = 1'b0;

        // spurious match flag outside CHECK
        core_en = 1'b0; spur_en = 1'b1;
        @(negedge clk); start = 1'b1;
        push_cands(16);
        for (int k = 0; k < 80; k++) begin
            @(negedge clk);
            if (k == 0) start = 1'b0;
            step_cmp("spur");
        end
        @(negedge clk);
        check("spur_done",  64'(done), 64'(1));
        check("spur_found", 64'(found), 64'(0));
        spur_en = 1'b0;

        // single-candidate space
        @(negedge clk); start2 = 1'b1;
        exp2_q.push_back({2'b11, 16'h0000});
        exp2_q.push_back({2'b10, 16'h5A5A});
        exp2_q.push_back(18'h0);
        exp2_q.push_back(18'h0);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            if (k == 0) start2 = 1'b0;
            e2 = (exp2_q.size() > 0) ? exp2_q.pop_front() : 18'h3FFFF;
            check("one", 64'({out_valid2, out_channel2, out_data2}), 64'(e2));
        end
        @(negedge clk);
        check("one_done",  64'(done2), 64'(1));
        check("one_found", 64'(found2), 64'(0));
        check("one_busy",  64'(busy2), 64'(0));
        check("one_fdata", 64'(found_data2), 64'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
